// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module      : ifu_fetch_pkg
// Description : Shared definitions for the instruction fetch unit: reset PC,
//               FSM state encoding, instruction field positions, opcode/funct
//               values and immediate helpers.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

  // Default PC loaded on reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Fetch FSM states
  typedef enum logic [0:0] {
    ST_REQ   = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Instruction field bit positions
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int INDEX_MSB  = 25;
  localparam int INDEX_LSB  = 0;

  // Opcode and funct values seen by the control decoder
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  // Sign-extend a 16-bit word offset and convert it to a byte offset
  function automatic logic [31:0] sext_imm_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_fetch_npc.sv
// ============================================================================
// Module      : ifu_fetch_npc
// Description : Combinational next-PC selection: jump target, taken branch
//               target or sequential PC+4, all modulo 2^32.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_fetch_npc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] npc
);

  logic [31:0] pc4;
  logic [31:0] target;

  assign pc4 = pc + 32'd4;

  // Jump beats branch; branch needs both the control and the condition flag
  always_comb begin
    target = pc4;
    if (jump) begin
      target = {pc4[31:28], instr_index, 2'b00};
    end else if (branch && zero) begin
      target = pc4 + sext_imm_x4(instr_index[15:0]);
    end
  end

  // Instruction addresses are word aligned whatever the reset PC was
  assign npc = {target[31:2], 2'b00};

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module      : ifu_fetch
// Description : Two-state instruction fetch unit. REQ requests the word at PC
//               and latches it into IR on ack; ISSUE presents the decoded
//               fields until the instruction retires and PC advances.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [5:0]       OpCode,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [15:0]      imm16,
  output logic [31:0]      pc,
  output logic             instr_valid,
  input  logic             jump,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             stall,
  output logic [CNT_W-1:0] retired
);

  state_t      state;
  logic [31:0] ir;
  logic [31:0] next_pc;

  ifu_fetch_npc u_npc (
    .pc          (pc),
    .instr_index (ir[INDEX_MSB:INDEX_LSB]),
    .jump        (jump),
    .branch      (Branch),
    .zero        (Zero),
    .npc         (next_pc)
  );

  // Fetch FSM: capture IR on ack, advance PC and count on unstalled issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_REQ;
      pc      <= RESET_PC;
      ir      <= 32'h0;
      retired <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            pc      <= next_pc;
            retired <= retired + CNT_W'(1);
            state   <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  assign imem_req    = (state == ST_REQ);
  assign instr_valid = (state == ST_ISSUE);
  assign imem_addr   = pc;

  assign OpCode = ir[OP_MSB:OP_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];
  assign rt     = ir[RT_MSB:RT_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign shamt  = ir[SHAMT_MSB:SHAMT_LSB];
  assign funct  = ir[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = ir[IMM_MSB:IMM_LSB];

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. Expected fetch addresses
//               are queued when an instruction retires and popped when the
//               DUT next requests memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic        instr_valid;
  logic        jump = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  retired;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [3:0]  m_ret;

  ifu_fetch #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .OpCode      (OpCode),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm16       (imm16),
    .pc          (pc),
    .instr_valid (instr_valid),
    .jump        (jump),
    .Branch      (Branch),
    .Zero        (Zero),
    .stall       (stall),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ir,
                                            input logic j, input logic b, input logic z);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (j) return {p4[31:28], ir[25:0], 2'b00};
    if (b && z) return p4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    return p4;
  endfunction

  // Serve one fetch after 'delay' idle cycles, then check the issued fields
  task automatic do_fetch(input logic [31:0] instr, input int delay);
    logic [31:0] a;
    int budget;
    budget = 0;
    while (!imem_req && budget < 20) begin
      step();
      budget++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      a = 32'hxxxx_xxxx;
    end else begin
      a = exp_q.pop_front();
    end
    chk("imem_addr", imem_addr, a);
    chk("req_valid_low", {31'b0, instr_valid}, 32'd0);
    for (int d = 0; d < delay; d++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      step();
      chk("addr_stable", imem_addr, a);
      chk("wait_valid_low", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_ir = instr;
    m_pc = a;
    chk("issue_valid", {31'b0, instr_valid}, 32'd1);
    chk("issue_req_low", {31'b0, imem_req}, 32'd0);
    chk("OpCode", {26'b0, OpCode}, {26'b0, instr[31:26]});
    chk("rs_rt_rd", {17'b0, rs, rt, rd}, {17'b0, instr[25:11]});
    chk("shamt_funct", {21'b0, shamt, funct}, {21'b0, instr[10:0]});
    chk("imm16", {16'b0, imm16}, {16'b0, instr[15:0]});
    chk("pc", pc, a);
  endtask

  // Hold in ISSUE for 'stalls' cycles with noisy ignored inputs, then retire
  task automatic do_issue(input logic j, input logic b, input logic z, input int stalls);
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      jump       = 1'b1;
      Branch     = 1'b1;
      Zero       = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      step();
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", pc, m_pc);
      chk("stall_ir", {16'b0, OpCode, funct, rs}, {16'b0, m_ir[31:26], m_ir[5:0], m_ir[25:21]});
      chk("stall_retired", {28'b0, retired}, {28'b0, m_ret});
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    jump     = j;
    Branch   = b;
    Zero     = z;
    exp_q.push_back(model_npc(m_pc, m_ir, j, b, z));
    m_ret = m_ret + 4'd1;
    step();
    jump   = 1'b0;
    Branch = 1'b0;
    Zero   = 1'b0;
    chk("retired", {28'b0, retired}, {28'b0, m_ret});
    chk("retire_valid_low", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    m_ret = 4'd0;
    // Reset held for two edges with a pending ack that must be ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_op_funct", {20'b0, OpCode, funct}, 32'd0);
    chk("rst_retired", {28'b0, retired}, 32'd0);
    imem_ack = 1'b0;
    rst      = 1'b0;
    exp_q.push_back(32'h0000_3000);

    // ori with same-cycle ack
    do_fetch(32'h3421_0005, 0);
    chk("ori_op", {26'b0, OpCode}, 32'h0D);
    chk("ori_imm", {16'b0, imm16}, 32'h5);
    do_issue(1'b0, 1'b0, 1'b0, 0);
    chk("seq_addr", imem_addr, 32'h0000_3004);

    do_fetch(32'h0043_0821, 0);
    do_issue(1'b0, 1'b0, 1'b0, 0);

    // Taken backward branch at 0x3008
    do_fetch(32'h1000_FFFE, 1);
    do_issue(1'b0, 1'b1, 1'b1, 0);
    chk("br_taken", imem_addr, 32'h0000_3004);
    do_fetch(32'h0043_0821, 0);
    do_issue(1'b0, 1'b0, 1'b0, 0);

    // Not-taken branch at 0x3008
    do_fetch(32'h1000_FFFE, 0);
    do_issue(1'b0, 1'b1, 1'b0, 0);
    chk("br_not_taken", imem_addr, 32'h0000_300C);
    do_fetch(32'h0043_0821, 0);
    do_issue(1'b0, 1'b0, 1'b0, 0);

    // Jump at 0x3010
    do_fetch(32'h0800_0C10, 2);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    chk("jump_target", imem_addr, 32'h0000_3040);

    // Delayed ack and two stall cycles
    do_fetch(32'h0043_0821, 3);
    do_issue(1'b0, 1'b0, 1'b0, 2);

    // Negative branch wrapping below zero to 0xFFFFFFFC
    do_fetch(32'h1000_F3ED, 0);
    do_issue(1'b0, 1'b1, 1'b1, 0);
    chk("neg_wrap", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'h0043_0821, 0);
    do_issue(1'b0, 1'b0, 1'b0, 0);
    chk("pc4_wrap", imem_addr, 32'h0000_0000);

    // Jump wins over a simultaneously taken branch
    do_fetch(32'h0800_0C10, 0);
    do_issue(1'b1, 1'b1, 1'b1, 0);
    chk("jump_priority", imem_addr, 32'h0000_3040);

    // Mixed traffic; carries the 4-bit retired counter through its wrap
    for (int k = 0; k < 6; k++) begin
      do_fetch(32'h0043_0821, int'($urandom_range(0, 2)));
      do_issue(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)));
    end

    // Reset in REQ with an ack in the same cycle
    imem_ack = 1'b0;
    step();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h3421_0005;
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd1);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0000_3000);
    chk("mid_rst_retired", {28'b0, retired}, 32'd0);
    chk("mid_rst_op", {26'b0, OpCode}, 32'd0);
    exp_q.delete();
    exp_q.push_back(32'h0000_3000);
    m_ret = 4'd0;

    do_fetch(32'h3421_0005, 0);
    do_issue(1'b0, 1'b0, 1'b0, 0);
    do_fetch(32'h0043_0821, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  byte address of requested word (= PC).
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle; may be high in the same cycle as imem_req.
REQ-008 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-009 OpCode  output  6  IR[31:26], to control decoder.
REQ-010 funct  output  6  IR[5:0], to control decoder.
REQ-011 rs, rt, rd  output  5 each  IR[25:21], IR[20:16], IR[15:11].
REQ-012 shamt  output  5  IR[10:6].
REQ-013 imm16  output  16  IR[15:0].
REQ-014 pc  output  32  address of instruction currently held in IR.
REQ-015 instr_valid  output  1  IR holds an instruction being executed this cycle.
REQ-016 jump  input  1  decoder jump control for the current instruction.
REQ-017 Branch  input  1  decoder branch control for the current instruction.
REQ-018 Zero  input  1  ALU branch-condition-met flag (covers beq and bne).
REQ-019 stall  input  1  hold current instruction in ISSUE for another cycle.
REQ-020 retired  output  CNT_W  count of instructions leaving ISSUE.

Function
REQ-021 FSM states SHALL be REQ, ISSUE; reset state REQ.
REQ-022 In REQ: imem_req=1, imem_addr=PC, instr_valid=0; on imem_ack=1 capture imem_rdata into IR and go ISSUE next cycle; otherwise stay in REQ with imem_addr held stable.
REQ-023 In ISSUE: imem_req=0, instr_valid=1; all IR-derived outputs and pc held stable.
REQ-024 In ISSUE with stall=1: stay in ISSUE, PC and IR unchanged, retired unchanged.
REQ-025 In ISSUE with stall=0: PC <= NPC, retired <= retired+1, go REQ next cycle.
REQ-026 NPC priority: jump=1 -> {PC4[31:28], IR[25:0], 2'b00}; else Branch=1 and Zero=1 -> PC4 + (sign-extended imm16 << 2); else PC4; PC4 = PC+4.
REQ-027 All NPC arithmetic SHALL be 32-bit modulo 2^32 (PC 32'hFFFF_FFFC -> PC4 32'h0000_0000; negative offsets wrap likewise).
REQ-028 jump, Branch, Zero SHALL be sampled only in ISSUE with stall=0; ignored elsewhere.
REQ-029 NPC low two bits SHALL always be 2'b00.
REQ-030 retired SHALL wrap from all-ones to zero.
REQ-031 Minimum instruction period SHALL be 2 cycles (REQ with same-cycle ack, then ISSUE).
REQ-032 imem_rdata SHALL be ignored when imem_ack=0 or state is ISSUE.

Reset
REQ-033 With rst=1 at a clock edge: state<=REQ, PC<=RESET_PC, IR<=32'h0, retired<=0, regardless of state or pending request.
REQ-034 During and after reset, outputs derive from reset registers: instr_valid=0, imem_req=1, imem_addr=RESET_PC, OpCode=funct=0.
REQ-035 Reset mid-request SHALL discard any ack arriving in the reset cycle.

Structure
REQ-036 Shared include SHALL hold RESET_PC default, state encodings, and instruction field bit positions alongside existing opcode/funct definitions.
REQ-037 Next-PC computation SHALL be one combinational sub-module npc (inputs PC, IR[25:0], jump, Branch, Zero; output NPC).

Verification
REQ-038 Reset, ack same cycle, IR=32'h3421_0005 (ori) -> imem_addr 32'h3000, ISSUE cycle 2 with OpCode 6'h0D, imm16 16'h0005; next imem_addr 32'h3004.
REQ-039 PC 32'h3008, Branch=1, Zero=1, imm16 16'hFFFE -> next imem_addr 32'h3004; with Zero=0 -> 32'h300C.
REQ-040 PC 32'h3010, jump=1, IR[25:0]=26'h0000C10 -> next imem_addr 32'h0000_3040.
REQ-041 ack delayed 3 cycles, then stall=1 for 2 ISSUE cycles -> imem_addr stable across wait, instr_valid high 3 cycles, retired increments by exactly 1.
REQ-042 PC 32'hFFFF_FFFC, no jump/branch -> next imem_addr 32'h0000_0000.
REQ-043 rst asserted in REQ with imem_ack=1 same cycle -> state REQ, imem_addr 32'h3000, instr_valid 0, retired 0 next cycle.
